// File: rtl/ex_muldiv_pkg.sv
// ex_muldiv_pkg: opcodes, FSM states and iteration count shared by the mul/div unit and its controller
package ex_muldiv_pkg;

    localparam logic [2:0] MD_MULT  = 3'b000;
    localparam logic [2:0] MD_MULTU = 3'b001;
    localparam logic [2:0] MD_DIV   = 3'b010;
    localparam logic [2:0] MD_DIVU  = 3'b011;
    localparam logic [2:0] MD_MTHI  = 3'b100;
    localparam logic [2:0] MD_MTLO  = 3'b101;

    localparam int MD_ITER = 32;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} md_state_t;

endpackage

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative 32-bit multiply/divide unit holding the architectural HI/LO registers
module ex_muldiv
    import ex_muldiv_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic        EX_MD_START,
    input  logic [2:0]  EX_MD_OP,
    input  logic [31:0] EX_D1,
    input  logic [31:0] EX_D2,
    output logic        MD_BUSY,
    output logic        MD_DONE,
    output logic [31:0] MD_HI,
    output logic [31:0] MD_LO
);

    md_state_t   state, state_next;
    logic [4:0]  cnt;
    logic [63:0] acc;
    logic [31:0] opnd, hi, lo;
    logic        sa, sb, dz, is_mul, done;
    logic        accept, start_mul, start_div, a_neg, b_neg;
    logic [31:0] a_abs, b_abs, quo_fix, rem_fix;
    logic [32:0] mul_sum, div_cand, div_diff;
    logic [63:0] prod_fix;

    assign accept    = EX_MD_START && !flush && state == IDLE;
    assign start_mul = accept && EX_MD_OP[2:1] == 2'b00;
    assign start_div = accept && EX_MD_OP[2:1] == 2'b01;
    assign a_neg     = !EX_MD_OP[0] && EX_D1[31];
    assign b_neg     = !EX_MD_OP[0] && EX_D2[31];
    assign a_abs     = a_neg ? -EX_D1 : EX_D1;
    assign b_abs     = b_neg ? -EX_D2 : EX_D2;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     state_next = start_mul ? MUL : start_div ? DIV : IDLE;
            MUL, DIV: state_next = cnt == '0 ? FIX : state;
            FIX:      state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        MD_BUSY = state != IDLE;
    end

    assign MD_DONE = done;
    assign MD_HI   = hi;
    assign MD_LO   = lo;

    // Shift-add keeps the multiplier in acc[31:0]; restoring divide shifts the dividend through acc.
    // The remainder never exceeds 32 bits, so bit 32 of the difference is the restore decision.
    assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    assign div_cand = acc[63:31];
    assign div_diff = div_cand - {1'b0, opnd};

    // With a zero divisor the datapath already returns |D1| as remainder, so only LO needs forcing.
    assign prod_fix = (sa ^ sb) ? -acc : acc;
    assign quo_fix  = dz ? '1 : (sa ^ sb) ? -acc[31:0] : acc[31:0];
    assign rem_fix  = sa ? -acc[63:32] : acc[63:32];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            dz     <= 1'b0;
            is_mul <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept && EX_MD_OP == MD_MTHI) hi <= EX_D1;
            if (accept && EX_MD_OP == MD_MTLO) lo <= EX_D1;
            if (start_mul || start_div) begin
                acc    <= {32'd0, start_mul ? b_abs : a_abs};
                opnd   <= start_mul ? a_abs : b_abs;
                sa     <= a_neg;
                sb     <= b_neg;
                dz     <= start_div && EX_D2 == '0;
                is_mul <= start_mul;
                cnt    <= 5'(MD_ITER - 1);
            end
            if (state == MUL) begin
                acc <= {mul_sum, acc[31:1]};
                cnt <= cnt - 5'd1;
            end
            if (state == DIV) begin
                acc <= div_diff[32] ? {div_cand[31:0], acc[30:0], 1'b0} : {div_diff[31:0], acc[30:0], 1'b1};
                cnt <= cnt - 5'd1;
            end
            if (state == FIX) begin
                hi   <= is_mul ? prod_fix[63:32] : rem_fix;
                lo   <= is_mul ? prod_fix[31:0] : quo_fix;
                done <= 1'b1;
            end
        end
    end

endmodule
